pp_accumulator: RTL and testbench

PP_ACCUMULATOR -- requirements
Module: pp_accumulator

---
 rtl/pp_accumulator.sv | 131 +++++++++++++
 tb/tb_pp_accumulator.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_accumulator.sv
// Assembles a 16-bit product from nine 3x3-bit slice partial products, taken one per cycle in any order.
// Result is valid one cycle after the 9th legal beat; pp_ready depends on state only and is high throughout ACCUM.
module pp_accumulator #(
    parameter int ACC_W = 18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        pp_valid,
    input  logic [5:0]  pp_data,
    input  logic [1:0]  pp_row,
    input  logic [1:0]  pp_col,
    output logic        pp_ready,
    output logic [15:0] result,
    output logic        result_valid,
    input  logic        result_ack,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [8:0]         seen_q, seen_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [3:0]         idx;
    logic [8:0]         idx_oh;
    logic [2:0]         slice_sum;
    logic [3:0]         shamt;
    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   acc_upper;
    logic               idx_legal;
    logic               dup;
    logic               beat_good;
    logic               overflow;

    always_comb begin
        idx       = ({2'b00, pp_row} * 4'd3) + {2'b00, pp_col};
        idx_oh    = 9'd1 << idx;
        idx_legal = (pp_row != 2'd3) && (pp_col != 2'd3);
        dup       = |(seen_q & idx_oh);
        beat_good = idx_legal && !dup;
        slice_sum = {1'b0, pp_row} + {1'b0, pp_col};
        shamt     = {1'b0, slice_sum} * 4'd3;
        addend    = ACC_W'(pp_data) << shamt;
        acc_sum   = acc_q + addend;
        // Anything above bit 15 means the beats could not have come from two 8-bit operands.
        acc_upper = acc_sum >> 16;
        overflow  = |acc_upper;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    seen_d  = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (start) begin
                    acc_d  = '0;
                    seen_d = '0;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                end else if (pp_valid) begin
                    if (beat_good) begin
                        acc_d  = acc_sum;
                        seen_d = seen_q | idx_oh;
                        cnt_d  = cnt_q + 4'd1;
                        if (cnt_q == 4'd8) begin
                            state_d = DONE;
                            err_d   = err_q | overflow;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    seen_d  = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else if (result_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            seen_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            seen_q  <= seen_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign pp_ready     = (state_q == ACCUM);
    assign result_valid = (state_q == DONE);
    assign result       = acc_q[15:0];
    assign err          = err_q;

endmodule

// File: tb/tb_pp_accumulator.sv
// Directed bench for pp_accumulator: stimulus pushes expected {result, err} per operation,
// a negedge monitor pops and compares on each rising result_valid.
module tb_pp_accumulator;

    logic        clock = 1'b0;
    logic        reset;
    logic        start = 1'b0;
    logic        pp_valid = 1'b0;
    logic [5:0]  pp_data = 6'd0;
    logic [1:0]  pp_row = 2'd0;
    logic [1:0]  pp_col = 2'd0;
    logic        pp_ready;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ack = 1'b0;
    logic        err;

    int tests = 0;
    int fails = 0;
    logic [16:0] exp_q[$];
    logic        rv_prev = 1'b0;

    pp_accumulator #(.ACC_W(18)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .pp_valid     (pp_valid),
        .pp_data      (pp_data),
        .pp_row       (pp_row),
        .pp_col       (pp_col),
        .pp_ready     (pp_ready),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .err          (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] sl(input logic [7:0] x, input int i);
        case (i)
            0:       return x[2:0];
            1:       return x[5:3];
            default: return {1'b0, x[7:6]};
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    task automatic beat(input logic [1:0] r, input logic [1:0] c, input logic [5:0] d);
        pp_valid = 1'b1;
        pp_row   = r;
        pp_col   = c;
        pp_data  = d;
        tick();
        pp_valid = 1'b0;
    endtask

    task automatic prod_beat(input logic [7:0] a, input logic [7:0] b, input int r, input int c);
        logic [5:0] p;
        p = {3'b000, sl(a, r)} * {3'b000, sl(b, c)};
        beat(2'(r), 2'(c), p);
    endtask

    task automatic run_row_major(input logic [7:0] a, input logic [7:0] b);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                prod_beat(a, b, r, c);
    endtask

    // Scoreboard monitor: one pop per DONE entry.
    always @(negedge clock) begin
        logic [16:0] e;
        if (reset && result_valid && !rv_prev) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: result %0h with no expected entry", result);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", 32'(result), 32'(e[16:1]));
                check("sb_err", 32'(err), 32'(e[0]));
            end
        end
        rv_prev = result_valid;
    end

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("rst_ready", 32'(pp_ready), 0);
        check("rst_rv", 32'(result_valid), 0);
        check("rst_result", 32'(result), 0);
        check("rst_err", 32'(err), 0);

        #10 reset = 1'b1;
        // Stay idle without start; ack and pp_valid ignored.
        result_ack = 1'b1;
        pp_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_ready", 32'(pp_ready), 0);
        end
        result_ack = 1'b0;
        pp_valid   = 1'b0;
        check("idle_rv", 32'(result_valid), 0);

        // FF x FF row-major, back to back
        do_start();
        check("t34_ready", 32'(pp_ready), 1);
        exp_q.push_back({16'hFE01, 1'b0});
        run_row_major(8'hFF, 8'hFF);
        check("t34_latency_rv", 32'(result_valid), 1);
        check("t34_ready_done", 32'(pp_ready), 0);
        do_ack();
        check("t34_idle_rv", 32'(result_valid), 0);
        check("t34_hold_result", 32'(result), 32'h0000FE01);

        // 0D x B6 reverse order with gaps
        do_start();
        exp_q.push_back({16'h093E, 1'b0});
        for (int r = 2; r >= 0; r--)
            for (int c = 2; c >= 0; c--) begin
                prod_beat(8'h0D, 8'hB6, r, c);
                tick();
            end
        check("t35_rv", 32'(result_valid), 1);
        check("t35_result", 32'(result), 32'h0000093E);
        do_ack();

        // 12 x 34 with a duplicated (1,1) as the 5th beat
        do_start();
        exp_q.push_back({16'h03A8, 1'b1});
        prod_beat(8'h12, 8'h34, 1, 1);
        prod_beat(8'h12, 8'h34, 0, 0);
        prod_beat(8'h12, 8'h34, 0, 1);
        prod_beat(8'h12, 8'h34, 0, 2);
        prod_beat(8'h12, 8'h34, 1, 1);
        check("t36_err_dup", 32'(err), 1);
        check("t36_rv_not_yet", 32'(result_valid), 0);
        prod_beat(8'h12, 8'h34, 1, 0);
        prod_beat(8'h12, 8'h34, 1, 2);
        prod_beat(8'h12, 8'h34, 2, 0);
        prod_beat(8'h12, 8'h34, 2, 1);
        check("t36_rv_8legal", 32'(result_valid), 0);
        prod_beat(8'h12, 8'h34, 2, 2);
        check("t36_rv", 32'(result_valid), 1);
        do_ack();
        check("t36_err_hold_idle", 32'(err), 1);

        // Accumulator bits above 15 on entry to DONE flag err
        do_start();
        check("ovf_err_cleared", 32'(err), 0);
        exp_q.push_back({16'h0000, 1'b1});
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (!(r == 2 && c == 2)) beat(2'(r), 2'(c), 6'd0);
        check("ovf_err_before", 32'(err), 0);
        beat(2'd2, 2'd2, 6'd16);
        do_ack();

        // Abort after 4 beats, then 03 x 05
        do_start();
        prod_beat(8'hFF, 8'hFF, 0, 0);
        prod_beat(8'hFF, 8'hFF, 0, 1);
        prod_beat(8'hFF, 8'hFF, 0, 2);
        prod_beat(8'hFF, 8'hFF, 1, 0);
        start = 1'b1;
        beat(2'd2, 2'd2, 6'd49);
        start = 1'b0;
        check("t37_ready", 32'(pp_ready), 1);
        check("t37_cleared", 32'(result), 0);
        exp_q.push_back({16'h000F, 1'b0});
        run_row_major(8'h03, 8'h05);
        do_ack();

        // start and ack together in DONE
        do_start();
        exp_q.push_back({16'h006E, 1'b0});
        run_row_major(8'h0A, 8'h0B);
        start      = 1'b1;
        result_ack = 1'b1;
        tick();
        start      = 1'b0;
        result_ack = 1'b0;
        check("t39_rv", 32'(result_valid), 0);
        check("t39_result", 32'(result), 0);
        check("t39_ready", 32'(pp_ready), 1);
        exp_q.push_back({16'h000F, 1'b1});
        beat(2'd3, 2'd1, 6'd7);
        run_row_major(8'h03, 8'h05);
        do_ack();

        // Async reset pulse mid-ACCUM
        do_start();
        prod_beat(8'hFF, 8'hFF, 0, 0);
        prod_beat(8'hFF, 8'hFF, 1, 1);
        prod_beat(8'hFF, 8'hFF, 2, 2);
        prod_beat(8'hFF, 8'hFF, 0, 1);
        beat(2'd0, 2'd3, 6'd1);
        check("t38_err_pre", 32'(err), 1);
        #2 reset = 1'b0;
        #1;
        check("t38_ready", 32'(pp_ready), 0);
        check("t38_rv", 32'(result_valid), 0);
        check("t38_result", 32'(result), 0);
        check("t38_err", 32'(err), 0);
        #2 reset = 1'b1;
        pp_valid = 1'b1;
        pp_row   = 2'd0;
        pp_col   = 2'd0;
        pp_data  = 6'd49;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t38_post_ready", 32'(pp_ready), 0);
            check("t38_post_result", 32'(result), 0);
        end
        pp_valid = 1'b0;

        check("sb_drain", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
